slow_clock_monitor: RTL and testbench

- Receiving end of the ripple clock-divider chain.
- Takes a divided or slow clock, such as the ÷512 output, back into the fast clk domain. Synchronises it and produces one-cycle edge ticks.
- Measures the period in clk cycles and reports lock and timeout status.
- Used wherever fast-domain logic must act on, or check, a divided clock.

---
 rtl/slow_clock_monitor.sv | 199 +++++++++++++++++++
 tb/tb_slow_clock_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/slow_clock_monitor.sv
// slow_clock_monitor
//   Receiving end of the ripple clock-divider chain. It brings a slow or divided
//   clock (for example the /512 tap) into the clk domain, turns its edges into
//   one-cycle ticks, measures the rise-to-rise period and reports whether that
//   period is stable (locked) or has stopped (timeout).
//
//   Optional build macro: SLOW_CLOCK_MONITOR_GLITCH_FILTER_EN
//     When defined, a level change must persist for 3 samples of the synchroniser
//     output before it is accepted. This ignores pulses shorter than 3 clk cycles
//     and raises edge latency from 3 to 5 clk edges.
//
//   Ports
//     clk          in   system clock, the only clock in the block
//     reset_n      in   asynchronous active-low reset
//     slow_in      in   asynchronous slow clock being monitored
//     rise_pulse   out  one-cycle tick per synchronised rising edge
//     fall_pulse   out  one-cycle tick per synchronised falling edge
//     period       out  last measured rise-to-rise period [CNT_W]
//     period_valid out  one-cycle strobe when period updates
//     locked       out  period within TOL for LOCK_CNT consecutive periods
//     timeout      out  no rising edge within 2^CNT_W-1 cycles
module slow_clock_monitor #(
  parameter int CNT_W    = 16,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             slow_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int               MW      = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_CNT);
  localparam logic [CNT_W:0]   TOL_V   = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  // ---------------------------------------------------------------- front end
  logic s1_q, s2_q, s3_q;
  logic lvl, rise, fall;
  logic rise_q, fall_q;

`ifdef SLOW_CLOCK_MONITOR_GLITCH_FILTER_EN
  logic h1_q, h2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h1_q <= 1'b0;
      h2_q <= 1'b0;
    end else begin
      h1_q <= s2_q;
      h2_q <= h1_q;
    end
  end

  // Accept a new level only when three consecutive s2 samples agree; otherwise
  // hold the previous accepted level, which s3 already carries.
  assign lvl = (s2_q == h1_q && h1_q == h2_q) ? s2_q : s3_q;
`else
  assign lvl = s2_q;
`endif

  assign rise = lvl & ~s3_q;
  assign fall = ~lvl & s3_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= slow_in;
      s2_q   <= s1_q;
      s3_q   <= lvl;
      rise_q <= rise;
      fall_q <= fall;
    end
  end

  // ---------------------------------------------------------- period counter
  // Restarts at 1 on the rise cycle, so at the next rise it holds exactly the
  // distance between the two rise_pulse assertions.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (rise)                 cnt_d = CNT_ONE;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // -------------------------------------------------------------- match test
  logic [CNT_W-1:0]        prev_q;
  logic                    have_prev_q;
  logic signed [CNT_W:0]   diff_s;
  logic        [CNT_W:0]   diff_mag;
  logic                    match;
  logic [MW-1:0]           mcnt_q, mcnt_inc;

  assign diff_s   = $signed({1'b0, cnt_q}) - $signed({1'b0, prev_q});
  assign diff_mag = diff_s[CNT_W] ? $unsigned(-diff_s) : $unsigned(diff_s);
  assign match    = have_prev_q && (diff_mag <= TOL_V);
  assign mcnt_inc = mcnt_q + MW'(1);

  // --------------------------------------------------------------------- FSM
  state_t           state_q;
  logic [CNT_W-1:0] period_q;
  logic             pv_q, locked_q, timeout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      period_q    <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      mcnt_q      <= '0;
      pv_q        <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // First edge only sets the reference; there is no period to report.
          if (rise) begin
            state_q     <= ACQUIRE;
            mcnt_q      <= '0;
            have_prev_q <= 1'b0;
            timeout_q   <= 1'b0;
          end
        end
        ACQUIRE: begin
          if (rise) begin
            period_q    <= cnt_q;
            pv_q        <= 1'b1;
            prev_q      <= cnt_q;
            have_prev_q <= 1'b1;
            if (match) begin
              mcnt_q <= mcnt_inc;
              if (mcnt_inc == LOCK_V) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              mcnt_q <= '0;
            end
          end else if (cnt_q == CNT_MAX) begin
            state_q     <= IDLE;
            timeout_q   <= 1'b1;
            locked_q    <= 1'b0;
            have_prev_q <= 1'b0;
            mcnt_q      <= '0;
          end
        end
        LOCKED: begin
          if (rise) begin
            period_q    <= cnt_q;
            pv_q        <= 1'b1;
            prev_q      <= cnt_q;
            have_prev_q <= 1'b1;
            if (!match) begin
              state_q  <= ACQUIRE;
              mcnt_q   <= '0;
              locked_q <= 1'b0;
            end
          end else if (cnt_q == CNT_MAX) begin
            state_q     <= IDLE;
            timeout_q   <= 1'b1;
            locked_q    <= 1'b0;
            have_prev_q <= 1'b0;
            mcnt_q      <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// tb_slow_clock_monitor
//   Drives slow_in as a clk-aligned square wave of chosen periods. Each driven
//   rising edge pushes the expected period/lock/timeout status into a queue;
//   every rise_pulse from the design pops and compares one entry.
module tb_slow_clock_monitor;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             slow_in = 1'b0;
  logic             rise_pulse, fall_pulse, period_valid, locked, timeout;
  logic [CNT_W-1:0] period;

  always #5 clk = ~clk;

  slow_clock_monitor #(.CNT_W(CNT_W), .TOL(2), .LOCK_CNT(4)) dut (
    .clk(clk), .reset_n(reset_n), .slow_in(slow_in),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .period(period),
    .period_valid(period_valid), .locked(locked), .timeout(timeout)
  );

  typedef struct {
    logic       pv;
    int         per;
    logic       lk;
    logic       to;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0, n_err = 0;
  int unsigned cyc = 0, last_rp_cyc = 0;
  int          n_rise = 0, n_fall = 0, n_fall_drv = 0;

  // reference model state
  int m_st = 0;        // 0 idle, 1 acquire, 2 locked
  int m_prev = 0, m_mcnt = 0, last_p = 0;
  bit m_hp = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_rise(input int p);
    exp_t e;
    bit   match;
    e.per = p;
    e.to  = 1'b0;
    if (m_st == 0) begin
      m_st = 1; m_mcnt = 0; m_hp = 0;
      e.pv = 1'b0; e.lk = 1'b0;
    end else begin
      match = m_hp && (p - m_prev <= 2) && (m_prev - p <= 2);
      e.pv = 1'b1;
      if (m_st == 1) begin
        m_mcnt = match ? m_mcnt + 1 : 0;
        if (m_mcnt == 4) m_st = 2;
      end else if (!match) begin
        m_st = 1; m_mcnt = 0;
      end
      m_prev = p; m_hp = 1;
      e.lk = (m_st == 2);
    end
    sb_q.push_back(e);
  endtask

  // One slow period of p cycles, starting with a rising edge on a negedge.
  task automatic per(input int p);
    slow_in = 1'b1;
    push_rise(last_p);
    last_p = p;
    repeat (p / 2) @(negedge clk);
    slow_in = 1'b0;
    n_fall_drv++;
    repeat (p - p / 2) @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (rise_pulse) begin
        n_rise++;
        last_rp_cyc = cyc;
        if (sb_q.size() == 0) chk("sb_unexpected_rise", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("period_valid", period_valid, e.pv);
          if (e.pv) chk("period", period, e.per);
          chk("locked", locked, e.lk);
          chk("timeout", timeout, e.to);
        end
      end
      if (fall_pulse) n_fall++;
      if (period_valid && !rise_pulse) chk("pv_without_rise", 1, 0);
      if (rise_pulse && fall_pulse) chk("rise_fall_overlap", 1, 0);
    end
  end

  initial begin
    int r0, f0, tw;
    bit seen;
    // reset held while slow_in toggles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      slow_in = ~slow_in;
    end
    chk("rst_rise", rise_pulse, 0);
    chk("rst_fall", fall_pulse, 0);
    chk("rst_period", period, 0);
    chk("rst_pv", period_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", timeout, 0);
    @(negedge clk);
    slow_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_rise", rise_pulse, 0);
    chk("idle_locked", locked, 0);
    chk("idle_period", period, 0);

    // nominal /512, lock on the 6th rise
    repeat (8) per(512);
    chk("nominal_locked", locked, 1);

    // jitter within tolerance, then a 520 step, then relock on 520
    per(513); per(511); per(512);
    repeat (5) per(520);
    per(512);
    chk("relock_520", locked, 1);

    // stop slow_in: timeout 65535 cycles after the last rise_pulse
    seen = 0;
    tw = 0;
    while (!seen && tw < 70000) begin
      @(negedge clk);
      tw++;
      if (timeout) seen = 1;
    end
    chk("timeout_seen", timeout, 1);
    chk("timeout_delay", longint'(cyc - last_rp_cyc), 65535);
    chk("timeout_locked", locked, 0);
    m_st = 0;
    repeat (5) @(negedge clk);
    chk("timeout_held", timeout, 1);
    repeat (7) per(512);
    chk("resume_locked", locked, 1);
    chk("resume_timeout", timeout, 0);

    // async reset pulse between clk edges while locked, slow_in low
    chk("sb_drained", sb_q.size(), 0);
    #3 reset_n = 1'b0;
    #1;
    chk("areset_locked", locked, 0);
    chk("areset_period", period, 0);
    chk("areset_timeout", timeout, 0);
    reset_n = 1'b1;
    m_st = 0;
    @(negedge clk);
    repeat (5) per(512);
    chk("relock_5_rises", locked, 0);
    per(512);
    chk("relock_6_rises", locked, 1);
    per(512);

    // one-cycle glitch from a fresh reset
    #3 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    m_st = 0;
    @(negedge clk);
    r0 = n_rise;
    f0 = n_fall;
    slow_in = 1'b1;
`ifndef SLOW_CLOCK_MONITOR_GLITCH_FILTER_EN
    push_rise(0);
    n_fall_drv++;
`endif
    @(negedge clk);
    slow_in = 1'b0;
    repeat (20) @(negedge clk);
`ifdef SLOW_CLOCK_MONITOR_GLITCH_FILTER_EN
    chk("glitch_rise", n_rise - r0, 0);
    chk("glitch_fall", n_fall - f0, 0);
`else
    chk("glitch_rise", n_rise - r0, 1);
    chk("glitch_fall", n_fall - f0, 1);
`endif
    chk("fall_total", n_fall, n_fall_drv);
    chk("sb_final", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
